link_game_control: RTL
======================

Name: link_game_control

Overview:
- Top-level sequencing FSM; the initiator side of the character-draw handshake.
- Drives the one-hot phase strobes (init, idle, apply_action, draw_map, draw_char) and the 3-bit user_input code to the map and character blocks.
- Waits on their map_done and draw_done responses.
- Paces the game at one action per frame and accumulates button presses between actions.

Parameters:
FRAME_CYCLES, 833333, idle length in clocks per frame (50 MHz / 60 Hz); minimum 2
TIMEOUT_CYCLES, 262144, maximum clocks to wait for map_done or draw_done before recovery
CNT_W, 20, width of the shared frame/watchdog counter; must hold max(FRAME_CYCLES, TIMEOUT_CYCLES)-1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
key_up, key_down, key_left, key_right, key_attack  in  1 each  synchronous active-high button levels
map_done  in  1  map renderer finished (pulse or level)
draw_done  in  1  character drawer finished (pulse or level)
init  out  1  character/map initialise strobe
idle  out  1  frame wait phase
apply_action  out  1  one-cycle strobe: consumer applies user_input
draw_map  out  1  map render phase
draw_char  out  1  character draw phase
user_input  out  3  action code: 000 NO_ACTION, 001 ATTACK, 010 UP, 011 DOWN, 100 LEFT, 101 RIGHT
timeout_err  out  1  sticky watchdog flag
state_dbg  out  3  current state encoding, for debug

Behaviour:
- Reset is asynchronous, active-low. While reset=0:
  - state = S_BOOT (000)
  - all strobes = 0; user_input = 000; timeout_err = 0
  - counter = 0; key accumulator = 0
- Outputs are registered Moore decodes of state. At most one of init/idle/apply_action/draw_map/draw_char is high in any cycle.
- States and transitions:
  - S_BOOT (000): no strobes. Goes to S_INIT on the first clock after reset release.
  - S_INIT (001): init=1 for exactly 1 cycle. Then S_MAP. Counter cleared.
  - S_MAP (010): draw_map=1. map_done sampled high goes to S_CHAR next cycle. A map_done high on the first cycle in S_MAP still exits after 1 cycle. Counter increments each cycle.
  - S_CHAR (011): draw_char=1. draw_done sampled high goes to S_IDLE. Counter cleared on entry, then increments.
  - S_IDLE (100): idle=1. Counter cleared on entry. Stays exactly FRAME_CYCLES cycles; exits when counter==FRAME_CYCLES-1. Then S_APPLY.
  - S_APPLY (101): apply_action=1 for exactly 1 cycle. Then S_MAP.
- Watchdog, in S_MAP or S_CHAR: if counter reaches TIMEOUT_CYCLES-1 with no done, go to S_INIT and set timeout_err=1. timeout_err is cleared only by reset. A done on the same cycle as expiry wins; no timeout is taken.
- done inputs are ignored in every state other than the one waiting on them. A level held high across states does not cause a skip: S_CHAR tests only draw_done.
- Key accumulator:
  - 5-bit sticky OR of the buttons, sampled every cycle in S_IDLE.
  - On the S_IDLE→S_APPLY transition, user_input is loaded with the priority-encoded accumulator and the accumulator is cleared.
  - Priority: attack > up > down > left > right. No key gives 000.
  - Opposing keys (up+down) resolve by priority, giving UP.
- user_input holds its value from S_APPLY until the next S_APPLY load, so it is stable while draw_char runs for facing selection. S_INIT forces user_input=000.
- Presses outside S_IDLE are not captured.
- Counter saturates at all-ones; it never wraps.
- Reset asserted mid-operation aborts immediately to S_BOOT with all outputs low. There is no partial-frame completion.

Test Plan (FRAME_CYCLES=8, TIMEOUT_CYCLES=32):
- Release reset → S_BOOT for 1 cycle, then init=1 for exactly 1 cycle, then draw_map=1; state_dbg sequence 000,001,010.
- map_done pulse 3 cycles into S_MAP, draw_done 5 cycles into S_CHAR → idle=1 for exactly 8 cycles, apply_action=1 for 1 cycle, then draw_map=1 again.
- key_left pulsed 1 cycle mid-idle, then key_up+key_down held at idle end → user_input=010 at apply_action; next frame with no keys gives 000.
- key_attack with key_right during idle → user_input=001. A key pressed only during S_CHAR → 000.
- Withhold draw_done → after 32 cycles in S_CHAR, state returns to S_INIT, init pulses, timeout_err=1 and stays 1 through subsequent normal frames.
- Assert reset low during S_IDLE cycle 4 → all outputs 0 asynchronously (before next clock edge), user_input=000; after release, normal S_BOOT→S_INIT sequence.

Source files
------------

// File: rtl/link_game_control.sv
// Top-level game sequencer: boot, initialise, then loop map render -> character
// draw -> frame wait -> action apply, with a watchdog on the two render handshakes.
module link_game_control #(
    parameter int unsigned FRAME_CYCLES   = 833333,
    parameter int unsigned TIMEOUT_CYCLES = 262144,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw_char,
    output logic [2:0] user_input,
    output logic       timeout_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'b000,
        S_INIT  = 3'b001,
        S_MAP   = 3'b010,
        S_CHAR  = 3'b011,
        S_IDLE  = 3'b100,
        S_APPLY = 3'b101
    } state_t;

    localparam logic [2:0] UI_NONE   = 3'b000;
    localparam logic [2:0] UI_ATTACK = 3'b001;
    localparam logic [2:0] UI_UP     = 3'b010;
    localparam logic [2:0] UI_DOWN   = 3'b011;
    localparam logic [2:0] UI_LEFT   = 3'b100;
    localparam logic [2:0] UI_RIGHT  = 3'b101;

    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       acc_q, acc_d;
    logic [2:0]       user_input_q, user_input_d;
    logic             timeout_err_q, timeout_err_d;
    logic             init_q, idle_q, apply_q, draw_map_q, draw_char_q;
    logic [4:0]       keys_now;
    logic             timeout_hit;
    logic             frame_end;

    // Accumulator bit order: {attack, up, down, left, right}
    assign keys_now = {key_attack, key_up, key_down, key_left, key_right};

    function automatic logic [2:0] encode_keys(input logic [4:0] k);
        logic [2:0] code;
        code = UI_NONE;
        if (k[4])      code = UI_ATTACK;
        else if (k[3]) code = UI_UP;
        else if (k[2]) code = UI_DOWN;
        else if (k[1]) code = UI_LEFT;
        else if (k[0]) code = UI_RIGHT;
        return code;
    endfunction

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            S_BOOT:  state_d = S_INIT;
            S_INIT:  state_d = S_MAP;
            S_MAP: begin
                // A done arriving on the expiry cycle takes priority over the watchdog.
                if (map_done) begin
                    state_d = S_CHAR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_INIT;
                    timeout_hit = 1'b1;
                end
            end
            S_CHAR: begin
                if (draw_done) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_INIT;
                    timeout_hit = 1'b1;
                end
            end
            S_IDLE: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d   = S_APPLY;
                    frame_end = 1'b1;
                end
            end
            S_APPLY: state_d = S_MAP;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (state_q == S_IDLE) begin
            acc_d = frame_end ? 5'b0 : (acc_q | keys_now);
        end
    end

    // The last idle cycle's keys are folded in directly so they count for this frame.
    always_comb begin
        user_input_d = user_input_q;
        if (state_d == S_INIT) begin
            user_input_d = UI_NONE;
        end else if (frame_end) begin
            user_input_d = encode_keys(acc_q | keys_now);
        end
    end

    assign timeout_err_d = timeout_err_q | timeout_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            cnt_q         <= '0;
            acc_q         <= 5'b0;
            user_input_q  <= UI_NONE;
            timeout_err_q <= 1'b0;
            init_q        <= 1'b0;
            idle_q        <= 1'b0;
            apply_q       <= 1'b0;
            draw_map_q    <= 1'b0;
            draw_char_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            user_input_q  <= user_input_d;
            timeout_err_q <= timeout_err_d;
            init_q        <= (state_d == S_INIT);
            idle_q        <= (state_d == S_IDLE);
            apply_q       <= (state_d == S_APPLY);
            draw_map_q    <= (state_d == S_MAP);
            draw_char_q   <= (state_d == S_CHAR);
        end
    end

    assign init         = init_q;
    assign idle         = idle_q;
    assign apply_action = apply_q;
    assign draw_map     = draw_map_q;
    assign draw_char    = draw_char_q;
    assign user_input   = user_input_q;
    assign timeout_err  = timeout_err_q;
    assign state_dbg    = state_q;

endmodule
